// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 max-pool over raster-ordered CONV output, one channel at a time
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int OFM_SIZE   = 62,
  parameter int CO         = 8,
  parameter int POOL_SIZE  = OFM_SIZE / 2
) (
  input  logic                  clk2,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_last,
  output logic                  o_done
);
  localparam int RW = $clog2(OFM_SIZE + 1);
  localparam int CW = CO > 1 ? $clog2(CO) : 1;
  localparam int LW = POOL_SIZE > 1 ? $clog2(POOL_SIZE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t                r_state, w_state_nxt;
  logic [RW-1:0]         r_col, r_row;
  logic [CW-1:0]         r_ch;
  logic [DATA_WIDTH-1:0] r_held, r_out_data;
  logic [DATA_WIDTH-1:0] r_lbuf [POOL_SIZE];
  logic                  r_out_valid, r_out_last;
  logic                  w_run, w_acc, w_win, w_fire, w_wr;
  logic                  w_col_end, w_row_end, w_ch_end, w_last;
  logic [LW-1:0]         w_k;
  logic [DATA_WIDTH-1:0] w_hmax, w_pmax;
  assign w_acc     = w_run & i_in_valid & ~i_start;
  assign w_col_end = r_col == RW'(OFM_SIZE - 1);
  assign w_row_end = r_row == RW'(OFM_SIZE - 1);
  assign w_ch_end  = r_ch == CW'(CO - 1);
  assign w_win     = (r_col < RW'(2 * POOL_SIZE)) & (r_row < RW'(2 * POOL_SIZE));
  assign w_fire    = w_acc & w_win & r_col[0] & r_row[0];
  assign w_wr      = w_acc & w_win & r_col[0] & ~r_row[0];
  assign w_last    = w_ch_end & (r_row == RW'(2 * POOL_SIZE - 1)) & (r_col == RW'(2 * POOL_SIZE - 1));
  assign w_k       = LW'(r_col >> 1);
  assign w_hmax    = $signed(r_held) > $signed(i_in_data) ? r_held : i_in_data;
  assign w_pmax    = $signed(r_lbuf[w_k]) > $signed(w_hmax) ? r_lbuf[w_k] : w_hmax;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  // state register
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  // next state: start always (re)arms; the final pooled output ends the frame
  always_comb begin
    w_state_nxt = r_state;
    if (i_start)                         w_state_nxt = S_RUN;
    else if (r_state == S_DONE)          w_state_nxt = S_IDLE;
    else if (r_state == S_RUN && r_out_last) w_state_nxt = S_DONE;
  end
  // state-decoded outputs
  always_comb begin
    w_run  = r_state == S_RUN;
    o_done = r_state == S_DONE;
  end
  // raster position counters: col -> row -> channel
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_ch  <= '0;
    end else if (i_start) begin
      r_col <= '0;
      r_row <= '0;
      r_ch  <= '0;
    end else if (w_acc) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) begin
        r_row <= w_row_end ? '0 : r_row + 1'b1;
        if (w_row_end) r_ch <= w_ch_end ? '0 : r_ch + 1'b1;
      end
    end
  // pair register and registered pooled output (1-cycle latency)
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      r_held      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_acc && !r_col[0]) r_held <= i_in_data;
      r_out_valid <= w_fire;
      r_out_last  <= w_fire & w_last;
      if (w_fire) r_out_data <= w_pmax;
    end
  // half-row line buffer: written on even rows, read on odd rows, never both for one entry
  always_ff @(posedge clk2)
    if (w_wr) r_lbuf[w_k] <= w_hmax;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: random and directed frames against a plain-arithmetic max-pool model
module tb_maxpool2x2_stream;
  logic        clk2 = 1'b0;
  logic        rst_n, in_valid;
  logic [15:0] in_data;
  logic [3:0]  st, ov, ol, dn;
  logic [15:0] od0, od1, od2, od3, odm;
  int cyc = 0;
  int sel = 0;
  int total = 0, bad = 0;
  int smp[$], t_in[$], gd[$], gl[$], gt[$], dq[$];
  always #5 clk2 = ~clk2;
  always @(posedge clk2) cyc <= cyc + 1;
  maxpool2x2_stream #(.DATA_WIDTH(16), .OFM_SIZE(4), .CO(1)) u0 (
    .clk2(clk2), .rst_n(rst_n), .i_start(st[0]), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_out_valid(ov[0]), .o_out_data(od0), .o_out_last(ol[0]), .o_done(dn[0]));
  maxpool2x2_stream #(.DATA_WIDTH(16), .OFM_SIZE(5), .CO(1)) u1 (
    .clk2(clk2), .rst_n(rst_n), .i_start(st[1]), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_out_valid(ov[1]), .o_out_data(od1), .o_out_last(ol[1]), .o_done(dn[1]));
  maxpool2x2_stream #(.DATA_WIDTH(16), .OFM_SIZE(4), .CO(2)) u2 (
    .clk2(clk2), .rst_n(rst_n), .i_start(st[2]), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_out_valid(ov[2]), .o_out_data(od2), .o_out_last(ol[2]), .o_done(dn[2]));
  maxpool2x2_stream u3 (
    .clk2(clk2), .rst_n(rst_n), .i_start(st[3]), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_out_valid(ov[3]), .o_out_data(od3), .o_out_last(ol[3]), .o_done(dn[3]));
  always_comb odm = sel == 0 ? od0 : sel == 1 ? od1 : sel == 2 ? od2 : od3;
  always @(negedge clk2) begin
    if (ov[sel] === 1'b1) begin
      gd.push_back(int'($signed(odm)));
      gl.push_back(int'(ol[sel]));
      gt.push_back(cyc);
    end
    if (dn[sel] === 1'b1) dq.push_back(cyc);
  end
  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(logic v, int x);
    @(negedge clk2);
    in_valid = v;
    in_data  = 16'(x);
  endtask
  task automatic send(int d, int gapmax, int stop_at);
    sel = d;
    gd.delete(); gl.delete(); gt.delete(); dq.delete(); t_in.delete();
    @(negedge clk2);
    st[d]    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk2);
    st[d] = 1'b0;
    for (int i = 0; i < smp.size(); i++) begin
      repeat ($urandom_range(gapmax, 0)) drive(1'b0, 0);
      drive(1'b1, smp[i]);
      t_in.push_back(cyc);
      if (i == stop_at) begin
        @(posedge clk2);
        #1;
        chk("abort_valid_before", logic'(ov[d]), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", logic'(ov[d]), 0);
        chk("abort_last", logic'(ol[d]), 0);
        chk("abort_done", logic'(dn[d]), 0);
        return;
      end
    end
    drive(1'b0, 0);
    repeat (4) @(negedge clk2);
  endtask
  function automatic int mx(int a, int b);
    return a > b ? a : b;
  endfunction
  task automatic check_frame(string tag, int ofm, int co);
    int p = ofm / 2;
    int n = 0;
    int nexp = p * p * co;
    for (int c = 0; c < co; c++)
      for (int pr = 0; pr < p; pr++)
        for (int pc = 0; pc < p; pc++) begin
          int b = c * ofm * ofm + 2 * pr * ofm + 2 * pc;
          int m = mx(mx(smp[b], smp[b + 1]), mx(smp[b + ofm], smp[b + ofm + 1]));
          if (n < gd.size()) begin
            chk($sformatf("%s data%0d", tag, n), gd[n], m);
            chk($sformatf("%s time%0d", tag, n), gt[n], t_in[b + ofm + 1] + 1);
            chk($sformatf("%s last%0d", tag, n), gl[n], int'(n == nexp - 1));
          end
          n++;
        end
    chk({tag, " count"}, gd.size(), nexp);
    chk({tag, " done_pulses"}, dq.size(), 1);
    if (dq.size() > 0 && gt.size() > 0) chk({tag, " done_time"}, dq[0], gt[gt.size() - 1] + 1);
  endtask
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; st = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      sel = d;
      #0;
      chk($sformatf("reset_valid%0d", d), logic'(ov[d]), 0);
      chk($sformatf("reset_data%0d", d), odm, 0);
      chk($sformatf("reset_last%0d", d), logic'(ol[d]), 0);
      chk($sformatf("reset_done%0d", d), logic'(dn[d]), 0);
    end
    repeat (3) @(negedge clk2);
    rst_n = 1'b1;
    smp.delete();
    for (int i = 1; i <= 16; i++) smp.push_back(i);
    send(0, 0, -1);
    check_frame("t1", 4, 1);
    send(0, 3, -1);
    check_frame("t4gaps", 4, 1);
    smp.delete();
    for (int i = 0; i <= 24; i++) smp.push_back(i);
    send(1, 0, -1);
    check_frame("t2odd", 5, 1);
    smp.delete();
    for (int i = 0; i < 32; i++) smp.push_back(i == 22 ? -1 : -5);
    send(2, 0, -1);
    check_frame("t3neg", 4, 2);
    @(negedge clk2);
    st[2] = 1'b1;
    @(negedge clk2);
    st[2] = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, int'($urandom_range(65535)) - 32768);
    smp.delete();
    for (int i = 0; i < 32; i++) smp.push_back(int'($urandom_range(65535)) - 32768);
    send(2, 2, -1);
    check_frame("restart", 4, 2);
    smp.delete();
    for (int i = 0; i < 8 * 62 * 62; i++) smp.push_back(int'($urandom_range(65535)) - 32768);
    send(3, 0, -1);
    check_frame("t5full", 62, 8);
    smp.delete();
    for (int i = 0; i < 8 * 62 * 62; i++) smp.push_back(int'($urandom_range(65535)) - 32768);
    send(3, 0, 3 * 3844 + 11 * 62 + 21);
    gd.delete(); dq.delete();
    drive(1'b0, 0);
    rst_n = 1'b1;
    repeat (30) drive(1'b1, 7);
    drive(1'b0, 0);
    repeat (3) @(negedge clk2);
    chk("post_reset_outputs", gd.size(), 0);
    chk("post_reset_done", dq.size(), 0);
    send(3, 0, -1);
    check_frame("t6replay", 62, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
